// File: rtl/led_matrix_scan.sv
// led_matrix_scan: double-buffered 8x8 RGB row-scan driver with tear-free front/back swap.
// Define SCAN_BLANK_EN to darken each row for its first BLANK_CYCLES cycles (anti-ghosting).
module led_matrix_scan #(
   parameter int CLK_DIV      = 10001,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_red,
   input  logic [7:0] wr_green,
   input  logic [7:0] wr_blue,
   input  logic       swap_req,
   output logic       swap_ack,
   output logic       frame_tick,
   output logic [3:0] comm,
   output logic [7:0] data_r,
   output logic [7:0] data_g,
   output logic [7:0] data_b
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_row;
   logic          r_front;
   logic          r_pending;
   logic          r_running;
   logic [23:0]   r_bank [2][8];

   logic          w_atLast;
   logic          w_swap;
   logic [CW-1:0] w_cntNext;
   logic [2:0]    w_rowNext;
   logic          w_frontNext;
   logic          w_backIdx;
   logic          w_blank;
   logic [23:0]   w_wrWord;
   logic [23:0]   w_rowWord;

   assign w_wrWord  = {wr_red, wr_green, wr_blue};
   assign w_backIdx = ~r_front;

   // The first edge after clear only arms the scan so that cnt=0/row=0 is displayed
   // (and frame_tick raised) in the first cycle after release; registered outputs are
   // computed from the next state so they line up with cnt/row of their own cycle.
   always_comb begin
      w_atLast    = (r_cnt == CNT_LAST);
      w_swap      = 1'b0;
      w_cntNext   = '0;
      w_rowNext   = 3'd0;
      if (r_running) begin
         w_swap    = w_atLast && (r_row == 3'd7) && (r_pending || swap_req);
         w_cntNext = w_atLast ? '0 : r_cnt + CW'(1);
         w_rowNext = w_atLast ? r_row + 3'd1 : r_row;
      end
      w_frontNext = r_front ^ w_swap;
      // A write landing at the same edge as the displayed row must be forwarded
      if (wr_en && (wr_row == w_rowNext) && (w_backIdx == w_frontNext)) begin
         w_rowWord = w_wrWord;
      end else begin
         w_rowWord = r_bank[w_frontNext][w_rowNext];
      end
   end

`ifdef SCAN_BLANK_EN
   localparam logic [CW:0] BLANK_LEN = (CW + 1)'(BLANK_CYCLES);
   assign w_blank = ({1'b0, w_cntNext} < BLANK_LEN);
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
               r_bank[b][r] <= '0;
            end
         end
         r_cnt      <= '0;
         r_row      <= 3'd0;
         r_front    <= 1'b0;
         r_pending  <= 1'b0;
         r_running  <= 1'b0;
         swap_ack   <= 1'b0;
         frame_tick <= 1'b0;
         comm       <= 4'b1000;
         data_r     <= 8'hFF;
         data_g     <= 8'hFF;
         data_b     <= 8'hFF;
      end else begin
         r_running <= 1'b1;
         r_cnt     <= w_cntNext;
         r_row     <= w_rowNext;
         r_front   <= w_frontNext;
         if (w_swap) begin
            r_pending <= 1'b0;
         end else if (swap_req) begin
            r_pending <= 1'b1;
         end
         // Writes always target the pre-swap back bank, so a coincident write joins the new frame
         if (wr_en) begin
            r_bank[w_backIdx][wr_row] <= w_wrWord;
         end
         swap_ack   <= w_swap;
         frame_tick <= (w_cntNext == '0) && (w_rowNext == 3'd0);
         comm       <= {1'b1, w_rowNext};
         if (w_blank) begin
            data_r <= 8'hFF;
            data_g <= 8'hFF;
            data_b <= 8'hFF;
         end else begin
            data_r <= ~w_rowWord[23:16];
            data_g <= ~w_rowWord[15:8];
            data_b <= ~w_rowWord[7:0];
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed self-checking bench for led_matrix_scan (CLK_DIV=8, BLANK_CYCLES=2).
// Every output is compared each cycle against hand-specified frame contents and swap points.
module tb_led_matrix_scan;

   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;

   logic       clk = 1'b0;
   logic       clear;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_red, wr_green, wr_blue;
   logic       swap_req;
   logic       swap_ack, frame_tick;
   logic [3:0] comm;
   logic [7:0] data_r, data_g, data_b;

   int tests = 0;
   int fails = 0;
   int k = 0;
   int ackCycle = -1;

   logic [7:0] expR [8];
   logic [7:0] expG [8];
   logic [7:0] expB [8];
   logic [7:0] nxtR [8];
   logic [7:0] nxtG [8];
   logic [7:0] nxtB [8];

   led_matrix_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .clear      (clear),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_red     (wr_red),
      .wr_green   (wr_green),
      .wr_blue    (wr_blue),
      .swap_req   (swap_req),
      .swap_ack   (swap_ack),
      .frame_tick (frame_tick),
      .comm       (comm),
      .data_r     (data_r),
      .data_g     (data_g),
      .data_b     (data_b)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s k=%0d got %0h expected %0h", tag, k, actual, expected);
      end
   endtask

   task automatic zeroFrames();
      for (int r = 0; r < 8; r++) begin
         expR[r] = 8'h00; expG[r] = 8'h00; expB[r] = 8'h00;
         nxtR[r] = 8'h00; nxtG[r] = 8'h00; nxtB[r] = 8'h00;
      end
   endtask

   // Expected outputs for scan cycle k counted from the first cycle after reset release
   task automatic checkCycle();
      int         row;
      int         cnt;
      logic [2:0] row3;
      logic       blank;
      row  = (k / CLK_DIV) % 8;
      cnt  = k % CLK_DIV;
      row3 = row[2:0];
      if (k == ackCycle) begin
         for (int r = 0; r < 8; r++) begin
            expR[r] = nxtR[r]; expG[r] = nxtG[r]; expB[r] = nxtB[r];
         end
      end
`ifdef SCAN_BLANK_EN
      blank = (cnt < BLANK);
`else
      blank = 1'b0;
`endif
      checkOutput("comm", {28'd0, comm}, {28'd0, 1'b1, row3});
      checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, (cnt == 0) && (row == 0)});
      checkOutput("swap_ack", {31'd0, swap_ack}, {31'd0, k == ackCycle});
      checkOutput("data_r", {24'd0, data_r}, {24'd0, blank ? 8'hFF : ~expR[row]});
      checkOutput("data_g", {24'd0, data_g}, {24'd0, blank ? 8'hFF : ~expG[row]});
      checkOutput("data_b", {24'd0, data_b}, {24'd0, blank ? 8'hFF : ~expB[row]});
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      k++;
      checkCycle();
   endtask

   task automatic runTo(input int target);
      while (k < target) stepCycle();
   endtask

   // Drives one cycle of write and/or swap request, then returns inputs to idle
   task automatic applyStimulus(input logic doWr, input logic [2:0] row, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b, input logic doSwap);
      wr_en    = doWr;
      wr_row   = row;
      wr_red   = r;
      wr_green = g;
      wr_blue  = b;
      swap_req = doSwap;
      stepCycle();
      wr_en    = 1'b0;
      swap_req = 1'b0;
   endtask

   // Holds clear for three cycles; junk=1 also drives a write and swap request that clear must override
   task automatic applyReset(input logic junk);
      clear = 1'b1;
      if (junk) begin
         wr_en = 1'b1; wr_row = 3'd5; wr_red = 8'hFF; wr_green = 8'hAA; wr_blue = 8'h55;
         swap_req = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_comm", {28'd0, comm}, 32'h8);
      checkOutput("rst_data_r", {24'd0, data_r}, 32'hFF);
      checkOutput("rst_data_g", {24'd0, data_g}, 32'hFF);
      checkOutput("rst_data_b", {24'd0, data_b}, 32'hFF);
      checkOutput("rst_swap_ack", {31'd0, swap_ack}, 32'h0);
      checkOutput("rst_frame_tick", {31'd0, frame_tick}, 32'h0);
      clear    = 1'b0;
      wr_en    = 1'b0;
      swap_req = 1'b0;
      zeroFrames();
      ackCycle = -1;
      k = -1;
      stepCycle();
   endtask

   initial begin
      clear = 1'b1; wr_en = 1'b0; wr_row = 3'd0;
      wr_red = 8'h00; wr_green = 8'h00; wr_blue = 8'h00; swap_req = 1'b0;
      zeroFrames();

      applyReset(1'b0);

      // Write row 3 and request a swap mid-frame; new frame appears at cycle 64
      runTo(2);
      applyStimulus(1'b1, 3'd3, 8'h80, 8'h0F, 8'h00, 1'b0);
      runTo(5);
      nxtR[3] = 8'h80; nxtG[3] = 8'h0F;
      ackCycle = 64;
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);

      // Back-buffer write without a swap must not disturb two full frames
      runTo(70);
      applyStimulus(1'b1, 3'd3, 8'h00, 8'hFF, 8'h00, 1'b0);
      runTo(191);

      // Coincident write and swap request in the row-7 boundary cycle
      zeroFrames();
      expR[3] = 8'h80; expG[3] = 8'h0F;
      nxtG[3] = 8'hFF; nxtB[7] = 8'h01;
      ackCycle = 192;
      applyStimulus(1'b1, 3'd7, 8'h00, 8'h00, 8'h01, 1'b1);
      runTo(256);

      // Three requests in one frame merge into a single swap at cycle 320
      for (int r = 0; r < 8; r++) begin
         nxtR[r] = 8'h00; nxtG[r] = 8'h00; nxtB[r] = 8'h00;
      end
      nxtR[3] = 8'h80; nxtG[3] = 8'h0F;
      runTo(260);
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
      runTo(270);
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
      runTo(280);
      ackCycle = 320;
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
      runTo(390);

      // Request then clear before the boundary: dropped, display dark, banks wiped
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
      runTo(400);
      applyReset(1'b1);
      runTo(130);
      ackCycle = 192;
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
      runTo(260);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Double-buffered row-scan driver for the 8x8 RGB LED matrix. It sits directly downstream of the snake game logic. The game writes the green (body), red (apple) and blue planes into a back buffer one row at a time, then requests a swap. The block multiplexes the front buffer onto the matrix row by row, with optional anti-ghost blanking, and presents tear-free frames.

## Interface
- `CLK_DIV`, default 10001: clk cycles per row dwell; legal range ≥ 2.
- `BLANK_CYCLES`, default 16: off cycles at the start of each row dwell; must be < `CLK_DIV`.

Ports:
- `clk` in 1: system clock; the only clock.
- `clear` in 1: reset; synchronous, active-high.
- `wr_en` in 1: write strobe into the back buffer.
- `wr_row` in 3: row index for the write.
- `wr_red`, `wr_green`, `wr_blue` in 8 each: row pixels; 1 = lit.
- `swap_req` in 1: request a front/back exchange; single-cycle pulse or level.
- `swap_ack` out 1: one-cycle pulse when the swap takes effect.
- `frame_tick` out 1: one-cycle pulse at the start of each row-0 dwell.
- `comm` out 4: {enable, row[2:0]} to the matrix row decoder.
- `data_r`, `data_g`, `data_b` out 8 each: column drive, active-low (0 = lit).

## Operation
- Storage: two banks, each 8 rows × 24 bits, plus a 1-bit `front` pointer; the other bank is the back buffer.
- Write path:
  - `wr_en` high stores {red, green, blue} of `wr_row` into the back bank at the clock edge.
  - The front bank is never writable.
- Swap:
  - `swap_req` sets a `pending` flag; further requests while pending merge into one.
  - At the last cycle of the row-7 dwell (`cnt` == `CLK_DIV`-1, `row` == 7) with `pending` set, the `front` pointer toggles and `pending` clears.
  - `swap_ack` = 1 in the following cycle, which is also the first cycle of row 0.
  - There is no copy: after a swap the back bank holds the previous frame, and the writer rewrites every row it needs.
- Scan:
  - Prescaler `cnt` runs 0..`CLK_DIV`-1; at wrap, `row` increments mod 8.
  - `comm` = {1, `row`}.
  - Data outputs are all-ones while `cnt` < `BLANK_CYCLES`; otherwise `data_x` = ~front[`row`].x.
- States: SCAN only, with `pending` as a sub-flag. No other FSM states.

## Timing
- All outputs are registered and reflect the `cnt`/`row` state of the same cycle.
- Reset values:
  - `comm` = 4'b1000; `data_r`/`g`/`b` = 8'hFF.
  - `swap_ack` = 0; `frame_tick` = 0.
  - `cnt` = 0, `row` = 0, `front` = 0, `pending` = 0.
  - Both banks cleared to 0.
- `frame_tick` = 1 in the cycle after a row-7→0 wrap. It is also high in the first cycle after reset release, because `cnt` = 0 and `row` = 0.
- Write latency: a write to the back bank is visible only after the next swap.
- Swap latency: from `pending` set to new-frame display is at most 8·`CLK_DIV` cycles.
- Write and swap in the same cycle: the write lands in the pre-swap back bank, so it is part of the newly displayed frame.
- `swap_req` in the same cycle as the swap boundary is honoured at that boundary.
- `clear` mid-frame or mid-pending:
  - All state returns to reset values at that edge.
  - The pending swap is dropped and no `swap_ack` is issued.
  - `clear` overrides `wr_en` and `swap_req`.
- Row cadence: exactly `CLK_DIV` cycles per row and 8·`CLK_DIV` per frame, with no jitter.

## Configuration
- `SCAN_BLANK_EN` defined: blanking as described; each row is dark for its first `BLANK_CYCLES` cycles.
- Not defined: `BLANK_CYCLES` is ignored and data is driven for the full dwell. `comm`, `frame_tick` and swap timing are unchanged.

## Test plan
Bench parameters: `CLK_DIV` = 8, `BLANK_CYCLES` = 2, `SCAN_BLANK_EN` defined.
- **Reset:** assert `clear` 3 cycles, release.
  - Required: `comm` = 4'b1000, all data = 8'hFF, `frame_tick` high in the first cycle after release.
  - Required: `comm` row steps 0→7→0 every 8 cycles.
- **Write then swap:**
  - Write row 3 with `wr_green` = 8'h0F and `wr_red` = 8'h80; pulse `swap_req` at cycle 5.
  - Required: `swap_ack` in the first row-0 cycle (cycle 64 after release).
  - Required: during row 3, cycles 2–7 of the dwell, `data_g` = 8'hF0, `data_r` = 8'h7F, `data_b` = 8'hFF; cycles 0–1 all-ones.
- **Back-buffer isolation:**
  - After the swap, write row 3 `wr_green` = 8'hFF with no `swap_req`.
  - Required: display still shows 8'hF0 for two full frames.
- **Coincident write/swap:**
  - Assert `wr_en` (row 7, `wr_blue` = 8'h01) and `swap_req` in the boundary cycle.
  - Required: the next frame shows `data_b` = 8'hFE on row 7; single `swap_ack`.
- **Merged requests and reset mid-pending:**
  - Three `swap_req` pulses in one frame → exactly one `swap_ack`.
  - Request then `clear` before the boundary → no `swap_ack`; display all-ones.
- **Macro off:** rebuild without `SCAN_BLANK_EN`.
  - Required: row 3 data valid from dwell cycle 0.
